// File: rtl/alu_mem_pkg.sv
// Shared types and constants for the ALU register-bus sequencer.
// Holds the controller state encoding, the ALU register map and the
// position of the done flag in the status register.
package alu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_OP,
    POLL,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned ADDR_OPA  = 0;
  localparam int unsigned ADDR_OPB  = 1;
  localparam int unsigned ADDR_CTRL = 2;
  localparam int unsigned ADDR_STAT = 3;

  localparam int unsigned STAT_DONE_BIT = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   req[1:0]    request vector
//   last_grant  index of the requester granted most recently
//   grant[1:0]  one-hot grant, or zero when nothing requests
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the one that was not
  // granted last wins.
  always_comb begin
    grant    = '0;
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/alu_mem_ctrl.sv
// Sequencer and round-robin arbiter for the ALU register bus.
// Accepts whole ALU operations from two requesters, writes operand A,
// operand B and the control register, polls status until done or until
// TIMEOUT polls have gone unanswered, then returns the result tagged with
// the owning requester.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid / req_ready       per-requester operation handshake
//   req{0,1}_a/_b/_op           requester operands and opcode
//   rsp_valid / rsp_ready       response handshake
//   rsp_id / rsp_result/rsp_err response owner, result, timeout flag
//   addr/wr_data/rd_wr/enable   ALU register bus master outputs
//   rd_data, res_out            ALU read data and result
module alu_mem_ctrl
  import alu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RES_WIDTH  = 16,
  parameter int OP_WIDTH   = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [RES_WIDTH-1:0]  rsp_result,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_wr,
  output logic                  enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [RES_WIDTH-1:0]  res_out
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic                    id_q, id_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        poll_cnt_q, poll_cnt_d;
  logic [RES_WIDTH-1:0]    result_q, result_d;
  logic                    err_q, err_d;
  logic [1:0]              grant;
  logic                    stat_done;
  logic                    unused_rd_data;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    stat_done      = rd_data[STAT_DONE_BIT];
    // Only the done flag of the status register is meaningful.
    unused_rd_data = ^rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      poll_cnt_q   <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      poll_cnt_q   <= poll_cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    poll_cnt_d   = poll_cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d          = grant[1] ? req1_a  : req0_a;
          b_d          = grant[1] ? req1_b  : req0_b;
          op_d         = grant[1] ? req1_op : req0_op;
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = WR_A;
        end
      end
      WR_A:  state_d = WR_B;
      WR_B:  state_d = WR_OP;
      WR_OP: begin
        poll_cnt_d = '0;
        state_d    = POLL;
      end
      POLL:  state_d = WAIT;
      WAIT: begin
        // Done takes priority over timeout on the final poll.
        if (stat_done) begin
          result_d = res_out;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (poll_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          poll_cnt_d = poll_cnt_q + CNT_W'(1);
          state_d    = POLL;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and response outputs, decoded from registered state only.
  always_comb begin
    enable     = 1'b0;
    rd_wr      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    rsp_valid  = (state_q == RESP);
    rsp_id     = id_q;
    rsp_result = result_q;
    rsp_err    = err_q;
    req_ready  = (state_q == IDLE) ? grant : 2'b00;
    case (state_q)
      WR_A: begin
        enable  = 1'b1;
        addr    = ADDR_WIDTH'(ADDR_OPA);
        wr_data = a_q;
      end
      WR_B: begin
        enable  = 1'b1;
        addr    = ADDR_WIDTH'(ADDR_OPB);
        wr_data = b_q;
      end
      WR_OP: begin
        enable  = 1'b1;
        addr    = ADDR_WIDTH'(ADDR_CTRL);
        wr_data = DATA_WIDTH'(op_q);
      end
      POLL: begin
        enable = 1'b1;
        rd_wr  = 1'b1;
        addr   = ADDR_WIDTH'(ADDR_STAT);
      end
      default: ;
    endcase
  end

endmodule
